dac_stream_ctrl: RTL and testbench

//  Parametrised multi-channel DAC command sequencer between the sample FIFO (AXIS slave) and SPI master (AXIS master).

---
 rtl/dac_stream_ctrl_pkg.sv | 20 ++
 rtl/dac_stream_ctrl_if.sv | 32 +++
 rtl/dac_stream_ctrl_out_reg.sv | 36 +++
 rtl/dac_stream_ctrl.sv | 164 ++++++++++++++++
 tb/tb_dac_stream_ctrl.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dac_stream_ctrl_pkg.sv
// rtl/dac_stream_ctrl_pkg.sv - shared types and constants for the DAC command sequencer
// Purpose: FSM state enum, default command header/init word, command width helper.
// Ports: none (package).
package dac_stream_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } dac_state_e;

  localparam int                   DAC_HDR_W     = 4;
  localparam logic [DAC_HDR_W-1:0] DAC_HDR_BASE  = 4'b0001;
  localparam logic [23:0]          DAC_INIT_WORD = 24'h200008;

  function automatic int cmd_width(input int hdr_w, input int data_w);
    return hdr_w + data_w;
  endfunction

endpackage

// File: rtl/dac_stream_ctrl_if.sv
// rtl/dac_stream_ctrl_if.sv - sample-in / command-out stream bundle
// Purpose: groups the sample frame stream (s_axis_*) and SPI command stream (m_axis_*).
// Ports (modport master = sequencer side):
//   s_axis_tdata/tvalid in, s_axis_tready out   sample frames from FIFO
//   m_axis_tdata/tvalid out, m_axis_tready in   DAC commands to SPI master
// modport slave is the mirror image (FIFO + SPI master side).
interface dac_stream_ctrl_if
  import dac_stream_ctrl_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int LANE_W = 32,
  parameter int CMD_W  = cmd_width(DAC_HDR_W, 20)
) ();

  logic [NUM_CH*LANE_W-1:0] s_axis_tdata;
  logic                     s_axis_tvalid;
  logic                     s_axis_tready;
  logic [CMD_W-1:0]         m_axis_tdata;
  logic                     m_axis_tvalid;
  logic                     m_axis_tready;

  modport master (
    input  s_axis_tdata, s_axis_tvalid, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid
  );

  modport slave (
    output s_axis_tdata, s_axis_tvalid, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tvalid
  );

endinterface

// File: rtl/dac_stream_ctrl_out_reg.sv
// rtl/dac_stream_ctrl_out_reg.sv - single stream register stage (load/hold/clear)
// Purpose: holds one command word stable until accepted.
// Ports:
//   clk, rst_n         clock, async active-low reset
//   load, load_data    capture a new word (only when can_load)
//   tready             downstream ready
//   tdata, tvalid      registered output word
//   can_load           register empty or being accepted this cycle
module dac_axis_out_reg #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         tready,
  output logic [W-1:0] tdata,
  output logic         tvalid,
  output logic         can_load
);

  assign can_load = !tvalid || tready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tvalid <= 1'b0;
      tdata  <= '0;
    end else if (load) begin
      tvalid <= 1'b1;
      tdata  <= load_data;
    end else if (tready) begin
      tvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/dac_stream_ctrl.sv
// rtl/dac_stream_ctrl.sv - multi-channel DAC command sequencer
// Purpose: plays an init-command table after reset or re-init, then turns packed
//   multi-channel sample frames into per-channel DAC write commands.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   bus (master)   s_axis_* sample frames in, m_axis_* commands out
//   cfg_reinit     one-cycle pulse: replay init table
//   init_done      high while streaming (registered)
//   underrun_cnt   saturating count of starved cycles while streaming
module dac_stream_ctrl
  import dac_stream_ctrl_pkg::*;
#(
  parameter int                NUM_CH   = 2,
  parameter int                LANE_W   = 32,
  parameter int                DATA_W   = 20,
  parameter int                HDR_W    = DAC_HDR_W,
  parameter logic [HDR_W-1:0]  HDR_BASE = DAC_HDR_BASE,
  parameter int                INIT_LEN = 1,
  parameter logic [((INIT_LEN > 0) ? INIT_LEN : 1)*cmd_width(HDR_W, DATA_W)-1:0]
                               INIT_TABLE = DAC_INIT_WORD
) (
  input  logic               clk,
  input  logic               rst_n,
  dac_stream_ctrl_if.master  bus,
  input  logic               cfg_reinit,
  output logic               init_done,
  output logic [15:0]        underrun_cnt
);

  localparam int CMD_W = cmd_width(HDR_W, DATA_W);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  dac_state_e               state;
  logic [4:0]               init_idx;     // next table word to load
  logic [CH_W-1:0]          ch_idx;
  logic                     frame_vld;
  logic                     reinit_pend;
  logic                     seen_frame;
  logic [NUM_CH*LANE_W-1:0] frame_buf;

  logic                     can_load;
  logic                     accepted;
  logic                     last_ch;
  logic                     ch_load;
  logic                     s_fire;
  logic                     restart;
  logic                     init_load;
  logic                     load;
  logic [4:0]               init_sel;
  logic [DATA_W-1:0]        lane_code;
  logic [CMD_W-1:0]         load_data;
  int                       tbl_idx;

  assign accepted = bus.m_axis_tvalid && bus.m_axis_tready;
  assign last_ch  = (ch_idx == CH_W'(NUM_CH - 1));
  assign ch_load  = (state != ST_INIT) && frame_vld && can_load;
  assign s_fire   = bus.s_axis_tvalid && bus.s_axis_tready;

  // A re-init request seen in INIT restarts the table as soon as the word in
  // flight has left the output register.
  assign restart   = (state == ST_INIT) && reinit_pend && can_load;
  assign init_sel  = restart ? 5'd0 : init_idx;
  assign init_load = (state == ST_INIT) && can_load && (init_sel < 5'(INIT_LEN));
  assign load      = init_load || ch_load;

  // Accept the next frame while idle, or in the cycle its predecessor's last
  // channel moves into the output register, for gap-free back-to-back frames.
  assign bus.s_axis_tready = (state == ST_STREAM) && (!frame_vld || (last_ch && ch_load));

  assign lane_code = frame_buf[int'(ch_idx)*LANE_W +: DATA_W];

  always_comb begin
    tbl_idx   = (init_sel < 5'(INIT_LEN)) ? int'(init_sel) : 0;
    load_data = '0;
    if (state == ST_INIT) begin
      load_data = INIT_TABLE[tbl_idx*CMD_W +: CMD_W];
    end else begin
      load_data = {HDR_BASE + HDR_W'(ch_idx), lane_code};
    end
  end

  dac_axis_out_reg #(.W(CMD_W)) u_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .load_data (load_data),
    .tready    (bus.m_axis_tready),
    .tdata     (bus.m_axis_tdata),
    .tvalid    (bus.m_axis_tvalid),
    .can_load  (can_load)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= (INIT_LEN == 0) ? ST_STREAM : ST_INIT;
      init_idx     <= '0;
      ch_idx       <= '0;
      frame_vld    <= 1'b0;
      frame_buf    <= '0;
      reinit_pend  <= 1'b0;
      seen_frame   <= 1'b0;
      init_done    <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      if (cfg_reinit) reinit_pend <= 1'b1;

      case (state)
        ST_INIT: begin
          if (init_load) init_idx <= init_sel + 5'd1;
          if (restart) reinit_pend <= cfg_reinit;
          // Only one word is ever in flight, so accepting with the table
          // exhausted means the last init word just left.
          if (!reinit_pend && accepted && init_idx == 5'(INIT_LEN)) begin
            state      <= ST_STREAM;
            init_done  <= 1'b1;
            seen_frame <= 1'b0;
          end
        end
        ST_STREAM: begin
          if (reinit_pend) begin
            state     <= ST_DRAIN;
            init_done <= 1'b0;
          end else begin
            init_done <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (!frame_vld && can_load) begin
            reinit_pend <= cfg_reinit;
            init_idx    <= '0;
            if (INIT_LEN == 0) begin
              state      <= ST_STREAM;
              init_done  <= 1'b1;
              seen_frame <= 1'b0;
            end else begin
              state <= ST_INIT;
            end
          end
        end
        default: state <= ST_INIT;
      endcase

      if (ch_load) begin
        if (last_ch) begin
          ch_idx    <= '0;
          frame_vld <= 1'b0;
        end else begin
          ch_idx <= ch_idx + CH_W'(1);
        end
      end
      if (s_fire) begin
        frame_buf  <= bus.s_axis_tdata;
        frame_vld  <= 1'b1;
        seen_frame <= 1'b1;
      end

      if ((state == ST_STREAM) && seen_frame && !bus.m_axis_tvalid && !frame_vld &&
          !bus.s_axis_tvalid && (underrun_cnt != 16'hFFFF)) begin
        underrun_cnt <= underrun_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_dac_stream_ctrl.sv
// tb/tb_dac_stream_ctrl.sv - self-checking bench for dac_stream_ctrl
module tb_dac_stream_ctrl;

  localparam int NCH = 2;
  localparam int LW  = 32;
  localparam int CW  = 24;
  localparam logic [23:0] INIT_W = 24'h200008;
  localparam logic [23:0] B_W0   = 24'hA00001;
  localparam logic [23:0] B_W1   = 24'hA00002;
  localparam logic [23:0] B_W2   = 24'hA00003;

  logic        clk = 1'b0;
  logic        rst_a, rst_b, reinit_a, reinit_b, done_a, done_b;
  logic [15:0] und_a, und_b;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  dac_stream_ctrl_if #(.NUM_CH(NCH), .LANE_W(LW), .CMD_W(CW)) bus_a ();
  dac_stream_ctrl_if #(.NUM_CH(NCH), .LANE_W(LW), .CMD_W(CW)) bus_b ();

  dac_stream_ctrl dut_a (
    .clk(clk), .rst_n(rst_a), .bus(bus_a),
    .cfg_reinit(reinit_a), .init_done(done_a), .underrun_cnt(und_a)
  );

  dac_stream_ctrl #(.INIT_LEN(3), .INIT_TABLE({B_W2, B_W1, B_W0})) dut_b (
    .clk(clk), .rst_n(rst_b), .bus(bus_b),
    .cfg_reinit(reinit_b), .init_done(done_b), .underrun_cnt(und_b)
  );

  logic [23:0] exp_q[$];
  logic [63:0] tx_q[$];
  logic [23:0] got_q[$];
  logic        hold_v, s_pend;
  logic [23:0] hold_d;
  int          cyc, nout, first_out, last_out;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Command for channel ch of a frame: header 1+ch, low 20 bits of its lane.
  function automatic logic [23:0] cmd_of(input int ch, input logic [63:0] f);
    logic [31:0] lane;
    lane = f[ch*32 +: 32];
    return {4'(1 + ch), lane[19:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clock of dut_a with inputs already driven: stability check, scoreboard.
  task automatic a_cycle();
    #1;
    if (hold_v) begin
      chk("a_hold_valid", 32'(bus_a.m_axis_tvalid), 32'd1);
      chk("a_hold_data", 32'(bus_a.m_axis_tdata), 32'(hold_d));
    end
    s_pend = bus_a.s_axis_tvalid && !bus_a.s_axis_tready;
    if (bus_a.s_axis_tvalid && bus_a.s_axis_tready && tx_q.size() != 0) begin
      for (int c = 0; c < NCH; c++) exp_q.push_back(cmd_of(c, tx_q[0]));
      tx_q.delete(0);
    end
    if (bus_a.m_axis_tvalid && bus_a.m_axis_tready) begin
      chk("a_word_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        chk("a_word", 32'(bus_a.m_axis_tdata), 32'(exp_q[0]));
        exp_q.delete(0);
      end
      if (nout == 0) first_out = cyc;
      last_out = cyc;
      nout++;
    end
    hold_v = bus_a.m_axis_tvalid && !bus_a.m_axis_tready;
    hold_d = bus_a.m_axis_tdata;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic a_drive(input int vp, input int rp);
    if (!s_pend) begin
      bus_a.s_axis_tvalid = (tx_q.size() != 0) && ($urandom_range(99) < vp);
      bus_a.s_axis_tdata  = (tx_q.size() != 0) ? tx_q[0] : 64'd0;
    end
    bus_a.m_axis_tready = ($urandom_range(99) < rp);
  endtask

  task automatic a_run(input int max_cyc, input int vp, input int rp);
    int n;
    n = 0;
    while ((tx_q.size() != 0 || exp_q.size() != 0) && n < max_cyc) begin
      a_drive(vp, rp);
      a_cycle();
      n++;
    end
    chk("a_run_drained", 32'(exp_q.size() + tx_q.size()), 32'd0);
    bus_a.s_axis_tvalid = 1'b0;
    s_pend = 1'b0;
  endtask

  initial begin
    int  n;
    logic saw_low;
    rst_a = 1'b0; rst_b = 1'b0; reinit_a = 1'b0; reinit_b = 1'b0;
    bus_a.s_axis_tdata = '0; bus_a.s_axis_tvalid = 1'b0; bus_a.m_axis_tready = 1'b1;
    bus_b.s_axis_tdata = '0; bus_b.s_axis_tvalid = 1'b0; bus_b.m_axis_tready = 1'b0;
    hold_v = 1'b0; s_pend = 1'b0; hold_d = '0;
    cyc = 0; nout = 0; first_out = 0; last_out = 0;
    repeat (3) tick();

    // reset state
    chk("rst_tvalid", 32'(bus_a.m_axis_tvalid), 32'd0);
    chk("rst_tdata", 32'(bus_a.m_axis_tdata), 32'd0);
    chk("rst_s_tready", 32'(bus_a.s_axis_tready), 32'd0);
    chk("rst_init_done", 32'(done_a), 32'd0);
    chk("rst_underrun", 32'(und_a), 32'd0);
    chk("rst_b_tvalid", 32'(bus_b.m_axis_tvalid), 32'd0);
    chk("rst_b_underrun", 32'(und_b), 32'd0);

    // default init word: valid the cycle after release, single beat
    rst_a = 1'b1;
    tick();
    chk("t1_tvalid", 32'(bus_a.m_axis_tvalid), 32'd1);
    chk("t1_tdata", 32'(bus_a.m_axis_tdata), 32'(INIT_W));
    chk("t1_s_tready_init", 32'(bus_a.s_axis_tready), 32'd0);
    chk("t1_done_early", 32'(done_a), 32'd0);
    tick();
    chk("t1_one_beat", 32'(bus_a.m_axis_tvalid), 32'd0);
    chk("t1_done", 32'(done_a), 32'd1);
    chk("t1_s_tready", 32'(bus_a.s_axis_tready), 32'd1);

    // three-word table with toggling ready, offered frame must not be popped
    rst_b = 1'b1;
    bus_b.s_axis_tvalid = 1'b1;
    n = 0; hold_v = 1'b0; got_q.delete();
    while (got_q.size() < 3 && n < 40) begin
      bus_b.m_axis_tready = (n % 2) == 1;
      #1;
      if (hold_v) begin
        chk("t2_hold_valid", 32'(bus_b.m_axis_tvalid), 32'd1);
        chk("t2_hold_data", 32'(bus_b.m_axis_tdata), 32'(hold_d));
      end
      chk("t2_no_pop", 32'(bus_b.s_axis_tready), 32'd0);
      if (bus_b.m_axis_tvalid && bus_b.m_axis_tready) got_q.push_back(bus_b.m_axis_tdata);
      hold_v = bus_b.m_axis_tvalid && !bus_b.m_axis_tready;
      hold_d = bus_b.m_axis_tdata;
      tick();
      n++;
    end
    bus_b.s_axis_tvalid = 1'b0;
    hold_v = 1'b0;
    chk("t2_count", 32'(got_q.size()), 32'd3);
    if (got_q.size() == 3) begin
      chk("t2_w0", 32'(got_q[0]), 32'(B_W0));
      chk("t2_w1", 32'(got_q[1]), 32'(B_W1));
      chk("t2_w2", 32'(got_q[2]), 32'(B_W2));
    end
    chk("t2_done", 32'(done_b), 32'd1);

    // re-init during INIT restarts the table after the word in flight
    bus_b.m_axis_tready = 1'b0;
    reinit_b = 1'b1; tick(); reinit_b = 1'b0;
    n = 0;
    while (!bus_b.m_axis_tvalid && n < 10) begin tick(); n++; end
    chk("t2r_w0_valid", 32'(bus_b.m_axis_tvalid), 32'd1);
    chk("t2r_w0_data", 32'(bus_b.m_axis_tdata), 32'(B_W0));
    reinit_b = 1'b1; tick(); reinit_b = 1'b0;
    bus_b.m_axis_tready = 1'b1;
    got_q.delete(); n = 0;
    while (got_q.size() < 4 && n < 20) begin
      if (bus_b.m_axis_tvalid) got_q.push_back(bus_b.m_axis_tdata);
      tick();
      n++;
    end
    chk("t2r_count", 32'(got_q.size()), 32'd4);
    if (got_q.size() == 4) begin
      chk("t2r_seq0", 32'(got_q[0]), 32'(B_W0));
      chk("t2r_seq1", 32'(got_q[1]), 32'(B_W0));
      chk("t2r_seq2", 32'(got_q[2]), 32'(B_W1));
      chk("t2r_seq3", 32'(got_q[3]), 32'(B_W2));
    end

    // back-to-back frames: one command per cycle
    for (int i = 0; i < 4; i++) tx_q.push_back({32'h000ABCDE, 32'h00012345});
    nout = 0;
    a_run(100, 100, 100);
    chk("t3_words", 32'(nout), 32'd8);
    chk("t3_rate", 32'(last_out - first_out), 32'd7);

    // random traffic on both sides
    for (int i = 0; i < 30; i++) tx_q.push_back({$urandom, $urandom});
    a_run(800, 70, 60);

    // re-init after ch0 of a frame: ch1 still sent, then init word, then frames
    tx_q.push_back({$urandom, $urandom});
    n = 0;
    while ((tx_q.size() != 0 || exp_q.size() != 1) && n < 50) begin
      a_drive(100, 100);
      a_cycle();
      n++;
    end
    chk("t4_ch0_sent", 32'(exp_q.size()), 32'd1);
    bus_a.s_axis_tvalid = 1'b0;
    s_pend = 1'b0;
    exp_q.push_back(INIT_W);
    reinit_a = 1'b1;
    a_cycle();
    reinit_a = 1'b0;
    saw_low = 1'b0;
    n = 0;
    while ((exp_q.size() != 0 || !done_a) && n < 30) begin
      a_cycle();
      if (!done_a) saw_low = 1'b1;
      n++;
    end
    chk("t4_done_dropped", 32'(saw_low), 32'd1);
    chk("t4_replayed", 32'(exp_q.size()), 32'd0);
    chk("t4_done_back", 32'(done_a), 32'd1);
    for (int i = 0; i < 3; i++) tx_q.push_back({$urandom, $urandom});
    a_run(100, 80, 80);

    // underrun: 10 idle cycles after the first frame, then saturation
    rst_a = 1'b0; tick(); rst_a = 1'b1;
    hold_v = 1'b0; exp_q.delete(); tx_q.delete();
    bus_a.m_axis_tready = 1'b1;
    tick(); tick();
    chk("t5_stream", 32'(done_a), 32'd1);
    tx_q.push_back({$urandom, $urandom});
    a_run(40, 100, 100);
    chk("t5_start", 32'(und_a), 32'd0);
    repeat (10) tick();
    chk("t5_ten", 32'(und_a), 32'd10);
    repeat (65530) tick();
    chk("t5_saturate", 32'(und_a), 32'hFFFF);
    exp_q.push_back(INIT_W);
    reinit_a = 1'b1; a_cycle(); reinit_a = 1'b0;
    repeat (8) a_cycle();
    chk("t5_reinit_word", 32'(exp_q.size()), 32'd0);
    chk("t5_kept", 32'(und_a), 32'hFFFF);

    // asynchronous reset while a command is pending
    tx_q.push_back({$urandom, $urandom});
    n = 0;
    while (!bus_a.m_axis_tvalid && n < 20) begin
      a_drive(100, 0);
      a_cycle();
      n++;
    end
    chk("t6_pending", 32'(bus_a.m_axis_tvalid), 32'd1);
    #2;
    rst_a = 1'b0;
    #1;
    chk("t6_async_tvalid", 32'(bus_a.m_axis_tvalid), 32'd0);
    chk("t6_async_tdata", 32'(bus_a.m_axis_tdata), 32'd0);
    chk("t6_async_done", 32'(done_a), 32'd0);
    chk("t6_async_underrun", 32'(und_a), 32'd0);
    bus_a.s_axis_tvalid = 1'b0;
    s_pend = 1'b0; hold_v = 1'b0; exp_q.delete(); tx_q.delete();
    tick();
    rst_a = 1'b1;
    tick();
    chk("t6_restart_valid", 32'(bus_a.m_axis_tvalid), 32'd1);
    chk("t6_restart_word", 32'(bus_a.m_axis_tdata), 32'(INIT_W));
    bus_a.m_axis_tready = 1'b1;
    tick();
    chk("t6_done", 32'(done_a), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
